// File: rtl/led_expansion_driver_pkg.sv
// Shared encodings and the single-step LED transform for the LED expansion driver.
package led_expansion_driver_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'd0,
        MODE_ROT_LEFT  = 2'd1,
        MODE_ROT_RIGHT = 2'd2,
        MODE_BLINK     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] LED_RESET = 8'h01;

    // blink_dark=1 means the previous blink step blanked the LEDs, so the next one restores the pattern
    function automatic logic [7:0] step_led(input mode_e mode, input logic [7:0] led,
                                            input logic [7:0] pattern, input logic blink_dark);
        logic [7:0] res;
        res = led;
        case (mode)
            MODE_STATIC:    res = led;
            MODE_ROT_LEFT:  res = {led[6:0], led[7]};
            MODE_ROT_RIGHT: res = {led[0], led[7:1]};
            MODE_BLINK:     res = blink_dark ? pattern : 8'h00;
            default:        res = led;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable via clear.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 16777216
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_expansion_driver.sv
// Command-driven LED animator: accepts a pattern/mode/step-count and steps it on prescaler ticks.
module led_expansion_driver
    import led_expansion_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV = 16777216
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [7:0] CmdPattern,
    input  logic [1:0] CmdMode,
    input  logic [7:0] CmdSteps,
    output logic [7:0] LED,
    output logic       Busy,
    output logic       Done
);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [7:0] led_q, led_d;
    logic [7:0] pattern_q, pattern_d;
    logic [7:0] remain_q, remain_d;
    logic       dark_q, dark_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic accept;
    logic tick;

    assign accept = CmdValid && ready_q;

    // Prescaler only runs in RUN and restarts on every accepted command
    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .Clk   (Clk),
        .Rst   (Rst),
        .clear (accept || (state_q != ST_RUN)),
        .enable(state_q == ST_RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        led_d     = led_q;
        pattern_d = pattern_q;
        remain_d  = remain_q;
        dark_d    = dark_q;

        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    led_d = step_led(mode_q, led_q, pattern_q, dark_q);
                    if (mode_q == MODE_BLINK) begin
                        dark_d = !dark_q;
                    end
                    // remain_q==0 marks an endless command, so only finite counts decrement
                    if (remain_q != 8'd0) begin
                        remain_d = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        // A new command overrides whatever the tick would have done this cycle
        if (accept) begin
            led_d     = CmdPattern;
            pattern_d = CmdPattern;
            mode_d    = mode_e'(CmdMode);
            remain_d  = CmdSteps;
            dark_d    = 1'b0;
            state_d   = ST_RUN;
        end

        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE) || ((state_d == ST_RUN) && (remain_d == 8'd0));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_STATIC;
            led_q     <= LED_RESET;
            pattern_q <= 8'h00;
            remain_q  <= 8'd0;
            dark_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            pattern_q <= pattern_d;
            remain_q  <= remain_d;
            dark_q    <= dark_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CmdReady = ready_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_led_expansion_driver.sv
// Directed bench for led_expansion_driver with TICK_DIV=4: vector table plus multi-cycle sequences.
module tb_led_expansion_driver;

    localparam logic [1:0] M_STATIC = 2'd0;
    localparam logic [1:0] M_RL     = 2'd1;
    localparam logic [1:0] M_RR     = 2'd2;
    localparam logic [1:0] M_BLINK  = 2'd3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       CmdValid = 1'b0;
    logic       CmdReady;
    logic [7:0] CmdPattern = 8'h00;
    logic [1:0] CmdMode = 2'd0;
    logic [7:0] CmdSteps = 8'd0;
    logic [7:0] LED;
    logic       Busy;
    logic       Done;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] pat;
        logic [1:0] mode;
        logic [7:0] steps;
        logic [7:0] led;
        logic       rdy;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    led_expansion_driver #(.TICK_DIV(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdPattern(CmdPattern),
        .CmdMode   (CmdMode),
        .CmdSteps  (CmdSteps),
        .LED       (LED),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic add_vec(input logic r, input logic v, input logic [7:0] p, input logic [1:0] m,
                           input logic [7:0] s, input logic [7:0] el, input logic er,
                           input logic eb, input logic ed);
        vec_t t;
        t.rst = r; t.valid = v; t.pat = p; t.mode = m; t.steps = s;
        t.led = el; t.rdy = er; t.busy = eb; t.done = ed;
        vecs.push_back(t);
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling
    task automatic cyc(input logic r, input logic v, input logic [7:0] p, input logic [1:0] m,
                       input logic [7:0] s);
        Rst = r; CmdValid = v; CmdPattern = p; CmdMode = m; CmdSteps = s;
        @(posedge Clk);
        #1;
        if (Done) done_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, M_STATIC, 8'd0);
    endtask

    task automatic check(input string name, input logic [7:0] el, input logic er,
                         input logic eb, input logic ed);
        total++;
        if (LED !== el) begin
            bad++;
            $display("FAIL %s LED: got %02h want %02h", name, LED, el);
        end
        total++;
        if (CmdReady !== er) begin
            bad++;
            $display("FAIL %s CmdReady: got %b want %b", name, CmdReady, er);
        end
        total++;
        if (Busy !== eb) begin
            bad++;
            $display("FAIL %s Busy: got %b want %b", name, Busy, eb);
        end
        total++;
        if (Done !== ed) begin
            bad++;
            $display("FAIL %s Done: got %b want %b", name, Done, ed);
        end
    endtask

    initial begin
        // Finite ROT_LEFT run, with commands offered while CmdReady is low (incl. on the tick and in DONE)
        add_vec(1, 0, 8'h00, M_STATIC, 8'd0, 8'h01, 1, 0, 0);
        add_vec(0, 1, 8'h81, M_RL,     8'd3, 8'h81, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h81, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h81, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h81, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h03, 0, 1, 0);
        add_vec(0, 1, 8'hFF, M_BLINK,  8'd0, 8'h03, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h03, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h03, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h06, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h06, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h06, 0, 1, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h06, 0, 1, 0);
        add_vec(0, 1, 8'h3C, M_RR,     8'd1, 8'h0C, 0, 0, 1);
        add_vec(0, 1, 8'h3C, M_RR,     8'd1, 8'h0C, 1, 0, 0);
        add_vec(0, 0, 8'h00, M_STATIC, 8'd0, 8'h0C, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].valid, vecs[i].pat, vecs[i].mode, vecs[i].steps);
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].rdy, vecs[i].busy, vecs[i].done);
        end

        // Endless ROT_RIGHT, then a STATIC command offered exactly on a tick cycle
        cyc(0, 1, 8'h01, M_RR, 8'd0);
        check("rr_accept", 8'h01, 1, 1, 0);
        for (int t = 1; t < 16; t++) begin
            logic [7:0] exp_led;
            exp_led = (t < 4) ? 8'h01 : (t < 8) ? 8'h80 : (t < 12) ? 8'h40 : 8'h20;
            idle(1);
            check($sformatf("rr_t%0d", t), exp_led, 1, 1, 0);
        end
        cyc(0, 1, 8'h0F, M_STATIC, 8'd0);
        check("rr_replace_on_tick", 8'h0F, 1, 1, 0);
        idle(4);
        check("static_hold", 8'h0F, 1, 1, 0);

        // BLINK 0xAA for 4 steps with a single Done pulse
        cyc(0, 1, 8'hAA, M_BLINK, 8'd4);
        check("blink_accept", 8'hAA, 0, 1, 0);
        done_seen = 0;
        for (int k = 1; k <= 4; k++) begin
            idle(4);
            check($sformatf("blink_step%0d", k), (k % 2 == 1) ? 8'h00 : 8'hAA, 0,
                  (k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0);
        end
        idle(1);
        check("blink_idle", 8'hAA, 1, 0, 0);
        idle(3);
        check("blink_idle_hold", 8'hAA, 1, 0, 0);
        total++;
        if (done_seen != 1) begin
            bad++;
            $display("FAIL blink_done_count: got %0d want 1", done_seen);
        end

        // Zero pattern stays dark under rotation and blink
        cyc(0, 1, 8'h00, M_RL, 8'd2);
        check("zero_rl_accept", 8'h00, 0, 1, 0);
        idle(4);
        check("zero_rl_step1", 8'h00, 0, 1, 0);
        idle(4);
        check("zero_rl_done", 8'h00, 0, 0, 1);
        idle(1);
        cyc(0, 1, 8'h00, M_BLINK, 8'd2);
        check("zero_bl_accept", 8'h00, 0, 1, 0);
        idle(4);
        check("zero_bl_step1", 8'h00, 0, 1, 0);
        idle(4);
        check("zero_bl_done", 8'h00, 0, 0, 1);
        idle(1);
        check("zero_bl_idle", 8'h00, 1, 0, 0);

        // Reset mid-run while a command is offered and CmdReady is high
        cyc(0, 1, 8'h55, M_RL, 8'd0);
        check("rst_pre_accept", 8'h55, 1, 1, 0);
        idle(5);
        check("rst_pre_run", 8'hAA, 1, 1, 0);
        cyc(1, 1, 8'hF0, M_BLINK, 8'd0);
        check("rst_mid_run", 8'h01, 1, 0, 0);
        idle(5);
        check("rst_after", 8'h01, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
